// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, multdiv stall FSM,
// overflow/exception setx injection, and per-stage enables / next-insn muxing.
module pipeline_hazard_ctrl #(
    parameter int INSN_W     = 32,
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int MD_LATENCY = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ovf,
    input  logic              md_exc,
    input  logic [INSN_W-1:0] pc_insn,
    input  logic [INSN_W-1:0] fd_insn,
    input  logic [INSN_W-1:0] dx_insn,
    input  logic [INSN_W-1:0] xm_insn,
    input  logic              flush_fd,
    input  logic              flush_dx,
    input  logic              flush_xm,
    output logic [INSN_W-1:0] next_fd_insn,
    output logic [INSN_W-1:0] next_dx_insn,
    output logic [INSN_W-1:0] next_xm_insn,
    output logic [INSN_W-1:0] next_mw_insn,
    output logic              pc_en,
    output logic              fd_en,
    output logic              dx_en,
    output logic              xm_en,
    output logic              mw_en,
    output logic              md_start,
    output logic              md_busy,
    output logic              read_after_lw,
    output logic [1:0]        stall_cause
);

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_e;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [INSN_W-1:0] NOP         = '0;
    localparam logic [5:0]        MD_CNT_INIT = 6'(MD_LATENCY - 1);
    localparam logic [1:0]        LU_CNT_INIT = 2'(LOAD_STALL - 1);

    md_state_e   state_q, state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [1:0]  lu_cnt_q, lu_cnt_d;
    logic        md_exc_q, md_exc_d;

    logic [4:0]       fd_op, dx_op, dx_alu;
    logic [REG_W-1:0] fd_rd, fd_rs, fd_rt, dx_rd;
    logic             fd_reads_dx_rd;
    logic             dx_is_md;
    logic             md_launch, md_stall;
    logic             lu_hit, lu_stall;
    logic [26:0]      setx_code;
    logic [INSN_W-1:0] setx_insn;

    assign fd_op  = fd_insn[31:27];
    assign fd_rd  = fd_insn[26:22];
    assign fd_rs  = fd_insn[21:17];
    assign fd_rt  = fd_insn[16:12];
    assign dx_op  = dx_insn[31:27];
    assign dx_rd  = dx_insn[26:22];
    assign dx_alu = dx_insn[6:2];

    always_comb begin
        fd_reads_dx_rd = 1'b0;
        case (fd_op)
            OP_R:                   fd_reads_dx_rd = (fd_rs == dx_rd) || (fd_rt == dx_rd);
            OP_ADDI, OP_LW, OP_SW:  fd_reads_dx_rd = (fd_rs == dx_rd);
            OP_BNE, OP_BLT:         fd_reads_dx_rd = (fd_rs == dx_rd) || (fd_rd == dx_rd);
            OP_JR:                  fd_reads_dx_rd = (fd_rd == dx_rd);
            default:                fd_reads_dx_rd = 1'b0;
        endcase
    end

    assign dx_is_md  = (dx_op == OP_R) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));
    assign md_launch = (state_q == MD_IDLE) && dx_is_md && !flush_dx;
    assign md_stall  = md_launch || (state_q == MD_BUSY);
    assign lu_hit    = (dx_op == OP_LW) && (lu_cnt_q == 2'd0) && fd_reads_dx_rd;
    assign lu_stall  = lu_hit || (lu_cnt_q != 2'd0);

    always_comb begin
        setx_code = '0;
        if (dx_op == OP_ADDI) begin
            setx_code = 27'd2;
        end else if (dx_op == OP_R) begin
            case (dx_alu)
                ALU_ADD: setx_code = 27'd1;
                ALU_SUB: setx_code = 27'd3;
                ALU_MUL: setx_code = 27'd4;
                ALU_DIV: setx_code = 27'd5;
                default: setx_code = '0;
            endcase
        end
        setx_insn        = '0;
        setx_insn[31:27] = OP_SETX;
        setx_insn[26:0]  = setx_code;
    end

    // Multdiv sequencing; md_exc is captured on the last BUSY cycle for use in DONE.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        md_exc_d = md_exc_q;
        case (state_q)
            MD_IDLE: begin
                if (md_launch) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_CNT_INIT;
                end
            end
            MD_BUSY: begin
                if (flush_dx) begin
                    state_d  = MD_IDLE;
                    md_cnt_d = '0;
                    md_exc_d = 1'b0;
                end else if (md_cnt_q == 6'd0) begin
                    state_d  = MD_DONE;
                    md_exc_d = md_exc;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end
            MD_DONE: begin
                state_d  = MD_IDLE;
                md_exc_d = 1'b0;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Load-use countdown freezes while multdiv owns the front of the pipe.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (flush_fd || flush_dx) begin
            lu_cnt_d = '0;
        end else if (!md_stall) begin
            if (lu_hit) begin
                lu_cnt_d = LU_CNT_INIT;
            end else if (lu_cnt_q != 2'd0) begin
                lu_cnt_d = lu_cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= '0;
            lu_cnt_q <= '0;
            md_exc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            lu_cnt_q <= lu_cnt_d;
            md_exc_q <= md_exc_d;
        end
    end

    always_comb begin
        next_fd_insn  = NOP;
        next_dx_insn  = NOP;
        next_xm_insn  = NOP;
        next_mw_insn  = NOP;
        pc_en         = 1'b1;
        fd_en         = 1'b1;
        dx_en         = 1'b1;
        xm_en         = 1'b1;
        mw_en         = 1'b1;
        md_start      = 1'b0;
        md_busy       = 1'b0;
        read_after_lw = 1'b0;
        stall_cause   = 2'b00;
        if (!reset) begin
            next_fd_insn = flush_fd ? NOP : pc_insn;
            next_dx_insn = (flush_dx || lu_stall) ? NOP : fd_insn;
            if (flush_xm || md_stall) begin
                next_xm_insn = NOP;
            end else if ((state_q == MD_DONE) && md_exc_q) begin
                next_xm_insn = setx_insn;
            end else if (ovf && ((dx_op == OP_R) || (dx_op == OP_ADDI))) begin
                next_xm_insn = setx_insn;
            end else begin
                next_xm_insn = dx_insn;
            end
            next_mw_insn = xm_insn;
            if (md_stall) begin
                pc_en = 1'b0;
                fd_en = 1'b0;
                dx_en = 1'b0;
            end else if (lu_stall) begin
                pc_en = 1'b0;
                fd_en = 1'b0;
            end
            md_start      = md_launch;
            md_busy       = (state_q == MD_BUSY);
            read_after_lw = lu_stall;
            stall_cause   = {md_stall, lu_stall};
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised scoreboard bench for pipeline_hazard_ctrl: a behavioural pipeline model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    localparam int LS   = 3;
    localparam int ML   = 4;
    localparam int NCYC = 3000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ovf, md_exc;
    logic [31:0] pc_insn, fd_insn, dx_insn, xm_insn;
    logic        flush_fd, flush_dx, flush_xm;
    logic [31:0] next_fd_insn, next_dx_insn, next_xm_insn, next_mw_insn;
    logic        pc_en, fd_en, dx_en, xm_en, mw_en;
    logic        md_start, md_busy, read_after_lw;
    logic [1:0]  stall_cause;

    pipeline_hazard_ctrl #(
        .INSN_W(32), .REG_W(5), .LOAD_STALL(LS), .MD_LATENCY(ML)
    ) dut (
        .clock(clock), .reset(reset), .ovf(ovf), .md_exc(md_exc),
        .pc_insn(pc_insn), .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn),
        .flush_fd(flush_fd), .flush_dx(flush_dx), .flush_xm(flush_xm),
        .next_fd_insn(next_fd_insn), .next_dx_insn(next_dx_insn),
        .next_xm_insn(next_xm_insn), .next_mw_insn(next_mw_insn),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .md_start(md_start), .md_busy(md_busy), .read_after_lw(read_after_lw),
        .stall_cause(stall_cause)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] nfd, ndx, nxm, nmw;
        logic [4:0]  en;
        logic        start, busy, raw;
        logic [1:0]  cause;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] stream[$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] alu);
        return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic bit reads_reg(input logic [31:0] insn, input logic [4:0] r);
        logic [4:0] op = insn[31:27];
        logic [4:0] rd = insn[26:22];
        logic [4:0] rs = insn[21:17];
        logic [4:0] rt = insn[16:12];
        case (op)
            5'd0:             return (rs == r) || (rt == r);
            5'd5, 5'd7, 5'd8: return rs == r;
            5'd2, 5'd6:       return (rs == r) || (rd == r);
            5'd4:             return rd == r;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] setx_of(input logic [31:0] insn);
        int code = 0;
        logic [4:0] alu = insn[6:2];
        if (insn[31:27] == 5'd5) code = 2;
        else if (insn[31:27] == 5'd0) begin
            if (alu == 5'd0) code = 1;
            else if (alu == 5'd1) code = 3;
            else if (alu == 5'd6) code = 4;
            else if (alu == 5'd7) code = 5;
        end
        return 32'hA800_0000 | 32'(code);
    endfunction

    function automatic logic [31:0] rand_insn();
        int k = $urandom_range(0, 11);
        logic [4:0] a = 5'($urandom_range(0, 3));
        logic [4:0] b = 5'($urandom_range(0, 3));
        logic [4:0] c = 5'($urandom_range(0, 3));
        case (k)
            0:       return mk(5'd0, a, b, c, 5'd0);
            1:       return mk(5'd0, a, b, c, 5'd1);
            2:       return mk(5'd0, a, b, c, 5'd6);
            3:       return mk(5'd0, a, b, c, 5'd7);
            4:       return mk(5'd0, a, b, c, 5'($urandom_range(0, 31)));
            5:       return mk(5'd5, a, b, c, 5'($urandom_range(0, 31)));
            6, 7:    return mk(5'd8, a, b, c, 5'd0);
            8:       return mk(5'd7, a, b, c, 5'd0);
            9:       return mk(($urandom_range(0, 1) == 0) ? 5'd2 : 5'd6, a, b, c, 5'd0);
            10:      return mk(5'd4, a, b, c, 5'd0);
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle is a presented output; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("next_fd_insn", next_fd_insn, e.nfd);
                check("next_dx_insn", next_dx_insn, e.ndx);
                check("next_xm_insn", next_xm_insn, e.nxm);
                check("next_mw_insn", next_mw_insn, e.nmw);
                check("enables", {27'd0, pc_en, fd_en, dx_en, xm_en, mw_en}, {27'd0, e.en});
                check("md_start", {31'd0, md_start}, {31'd0, e.start});
                check("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
                check("read_after_lw", {31'd0, read_after_lw}, {31'd0, e.raw});
                check("stall_cause", {30'd0, stall_cause}, {30'd0, e.cause});
            end
        end
    end

    initial begin
        // Model state: pipeline contents plus remaining-cycle counters.
        logic [31:0] p_pc, p_fd, p_dx, p_xm;
        int  busy_left = 0, lu_left = 0;
        bit  in_done = 0, exc_l = 0, mid_rst_done = 0;
        bit  rst_v, ovf_v, exc_v, ffd, fdx, fxm;
        bit  is_md, launch, mst, luh, lst;
        exp_t e;

        p_pc = '0; p_fd = '0; p_dx = '0; p_xm = '0;
        // Directed opener: lw r3 / add r4,r3,r5 load-use, then mul and div.
        stream.push_back(mk(5'd8, 5'd3, 5'd1, 5'd0, 5'd0));
        stream.push_back(mk(5'd0, 5'd4, 5'd3, 5'd5, 5'd0));
        for (int i = 0; i < 4; i++) stream.push_back('0);
        stream.push_back(mk(5'd0, 5'd1, 5'd2, 5'd3, 5'd6));
        for (int i = 0; i < 4; i++) stream.push_back('0);
        stream.push_back(mk(5'd0, 5'd2, 5'd1, 5'd1, 5'd7));
        stream.push_back(mk(5'd5, 5'd1, 5'd1, 5'd0, 5'd0));

        @(posedge clock); #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            rst_v = (cyc < 2) || ($urandom_range(0, 199) == 0);
            if (!mid_rst_done && cyc > 40 && busy_left == ML - 1) begin
                rst_v = 1'b1;
                mid_rst_done = 1'b1;
            end
            ovf_v = ($urandom_range(0, 3) == 0);
            exc_v = (cyc < 40) ? 1'b1 : ($urandom_range(0, 1) == 1);
            ffd   = (cyc > 40) && ($urandom_range(0, 15) == 0);
            fdx   = (cyc > 40) && ($urandom_range(0, 15) == 0);
            fxm   = (cyc > 40) && ($urandom_range(0, 15) == 0);

            reset = rst_v; ovf = ovf_v; md_exc = exc_v;
            pc_insn = p_pc; fd_insn = p_fd; dx_insn = p_dx; xm_insn = p_xm;
            flush_fd = ffd; flush_dx = fdx; flush_xm = fxm;

            if (rst_v) begin
                e.nfd = '0; e.ndx = '0; e.nxm = '0; e.nmw = '0;
                e.en = 5'b11111; e.start = 0; e.busy = 0; e.raw = 0; e.cause = 2'b00;
                busy_left = 0; in_done = 0; exc_l = 0; lu_left = 0;
            end else begin
                is_md  = (p_dx[31:27] == 5'd0) && (p_dx[6:2] == 5'd6 || p_dx[6:2] == 5'd7);
                launch = (busy_left == 0) && !in_done && is_md && !fdx;
                mst    = launch || (busy_left > 0);
                luh    = (p_dx[31:27] == 5'd8) && (lu_left == 0) && reads_reg(p_fd, p_dx[26:22]);
                lst    = luh || (lu_left > 0);
                e.nfd  = ffd ? 32'd0 : p_pc;
                e.ndx  = (fdx || lst) ? 32'd0 : p_fd;
                if (fxm || mst) e.nxm = '0;
                else if (in_done && exc_l) e.nxm = setx_of(p_dx);
                else if (ovf_v && (p_dx[31:27] == 5'd0 || p_dx[31:27] == 5'd5)) e.nxm = setx_of(p_dx);
                else e.nxm = p_dx;
                e.nmw   = p_xm;
                e.en    = mst ? 5'b00011 : (lst ? 5'b00111 : 5'b11111);
                e.start = launch;
                e.busy  = (busy_left > 0);
                e.raw   = lst;
                e.cause = {mst, lst};

                if (ffd || fdx) lu_left = 0;
                else if (!mst) begin
                    if (luh) lu_left = LS - 1;
                    else if (lu_left > 0) lu_left--;
                end
                if (in_done) begin
                    in_done = 0; exc_l = 0;
                end else if (busy_left > 0) begin
                    if (fdx) begin
                        busy_left = 0; exc_l = 0;
                    end else begin
                        if (busy_left == 1) begin in_done = 1; exc_l = exc_v; end
                        busy_left--;
                    end
                end else if (launch) begin
                    busy_left = ML;
                end
            end
            sb.push_back(e);

            if (e.en[4]) p_pc = (stream.size() > 0) ? stream.pop_front() : rand_insn();
            if (e.en[3]) p_fd = e.nfd;
            if (e.en[2]) p_dx = e.ndx;
            if (e.en[1]) p_xm = e.nxm;

            @(posedge clock); #1;
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clock);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide parameters: INSN_W, default 32, instruction width; REG_W, default 5, register-specifier width; LOAD_STALL, default 1, range 1-3, load-use bubbles per hazard; MD_LATENCY, default 32, range 2-63, multdiv busy cycles.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports clock (in, 1, rising-edge) and reset (in, 1, synchronous active-high), listed first.
REQ-003 SHALL have inputs: ovf (1, ALU overflow for DX insn); md_exc (1, multdiv exception, valid on final busy cycle); pc_insn, fd_insn, dx_insn, xm_insn (INSN_W each, current stage contents); flush_fd, flush_dx, flush_xm (1 each, branch/jump squash).
REQ-004 SHALL have outputs: next_fd_insn, next_dx_insn, next_xm_insn, next_mw_insn (INSN_W each); pc_en, fd_en, dx_en, xm_en, mw_en (1 each); md_start (1, one-cycle multdiv launch pulse); md_busy (1); read_after_lw (1); stall_cause (2: 00 none, 01 load-use, 10 multdiv, 11 both).

Function
REQ-005 SHALL decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], alu_op [6:2]; opcodes R 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110; alu_op add 00000, sub 00001, mul 00110, div 00111.
REQ-006 SHALL define nop as all-zero INSN_W.
REQ-007 SHALL flag a load-use hazard (lu_hit) when lw is in DX, lu_cnt is 0, and FD reads DX rd: R-type via rs or rt; addi/lw/sw via rs; bne/blt via rs or rd; jr via rd.
REQ-008 SHALL hold lu_cnt (2-bit): on lu_hit load LOAD_STALL-1; else decrement if nonzero; load-use stall active when lu_hit or lu_cnt != 0.
REQ-009 SHALL drive read_after_lw equal to load-use stall active.
REQ-010 SHALL implement multdiv FSM IDLE/BUSY/DONE with 6-bit md_cnt.
REQ-011 IDLE -> BUSY when DX holds R-type mul or div and flush_dx is 0; md_start pulses 1 in that cycle; md_cnt loads MD_LATENCY-1.
REQ-012 BUSY: md_busy 1; md_cnt decrements each cycle; at md_cnt 0 go DONE.
REQ-013 DONE: lasts one cycle; returns to IDLE; mul/div insn advances to XM this cycle.
REQ-014 While in IDLE-launch cycle or BUSY: pc_en, fd_en, dx_en 0; next_xm_insn nop; xm_en, mw_en 1.
REQ-015 While load-use stall active and multdiv not stalling: pc_en, fd_en 0; next_dx_insn nop; dx_en, xm_en, mw_en 1.
REQ-016 When neither stall applies, all enables 1.
REQ-017 next_fd_insn = flush_fd ? nop : pc_insn.
REQ-018 next_dx_insn = (flush_dx or load-use stall) ? nop : fd_insn.
REQ-019 next_xm_insn priority: flush_xm -> nop; multdiv stall -> nop; DONE with md_exc latched -> setx; ovf with DX R-type/addi -> setx; else dx_insn.
REQ-020 setx = opcode 10101, bits [26:0] = addi 2, add 1, sub 3, mul 4, div 5, other 0.
REQ-021 md_exc SHALL be latched on final BUSY cycle and cleared on DONE exit.
REQ-022 next_mw_insn = xm_insn unconditionally.
REQ-023 flush_dx during BUSY SHALL abort to IDLE next cycle, clearing md_cnt and latched md_exc; flush_fd or flush_dx SHALL clear lu_cnt.
REQ-024 Simultaneous load-use and multdiv stall: stall_cause 11; multdiv rules win; lu_cnt frozen.

Reset
REQ-025 Reset SHALL force FSM IDLE, md_cnt 0, lu_cnt 0, latched md_exc 0.
REQ-026 During reset cycle: all next_* nop, all enables 1, md_start 0, md_busy 0, read_after_lw 0, stall_cause 00.
REQ-027 Reset asserted mid-BUSY SHALL abort the operation with no setx emitted.

Verification
REQ-028 lw r3 in DX, add r4,r3,r5 in FD, LOAD_STALL=1 -> one cycle pc_en=0, next_dx_insn=nop, read_after_lw=1; next cycle all enables 1.
REQ-029 Same with LOAD_STALL=3 -> exactly 3 consecutive stall cycles, then release.
REQ-030 mul in DX, MD_LATENCY=4 -> md_start one pulse, md_busy 4 cycles, XM gets nop 5 cycles, mul reaches XM on DONE.
REQ-031 div with md_exc=1 on last busy cycle -> next_xm_insn = setx with [26:0]=5 in DONE.
REQ-032 addi in DX with ovf=1 -> next_xm_insn = 0xA8000002; with flush_xm=1 simultaneously -> nop.
REQ-033 reset asserted on second BUSY cycle -> next cycle IDLE, md_busy 0, no setx.
